// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for mem_responder: FSM state encoding, the latched request
// record and the address legality check.
`timescale 1ns/1ps
package mem_responder_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  // A request is illegal when it is not word aligned or lies above the 2**aw word window.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous word RAM with per-byte write enables; read data is registered
// and holds until the next enabled read.
`timescale 1ns/1ps
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    wstrb_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (wstrb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, fixed LATENCY from accept to response.
// Optional MEM_RESPONDER_BACK_TO_BACK_EN lets a new request be accepted on the response handshake.
`timescale 1ns/1ps
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output state_t      dbg_state_o
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        err_q, err_d;
  logic        rd_sel_q, rd_sel_d;
  logic        active_q;
  logic        accept, commit, cur_err;
  logic [31:0] ram_rdata;

  assign cur_err = addr_err(req_q.addr, ADDR_WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and resp_valid/rdata/err hold until resp_ready is seen.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    err_d     = err_q;
    rd_sel_d  = rd_sel_q;
    req_ready = 1'b0;
    commit    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: req_ready = active_q;
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit   = 1'b1;
          err_d    = cur_err;
          rd_sel_d = !req_q.we && !cur_err;
          state_d  = RESP;
        end
      end
      RESP: begin
`ifdef MEM_RESPONDER_BACK_TO_BACK_EN
        req_ready = resp_ready;
`endif
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = req_valid && req_ready;
    if (accept) begin
      req_d   = '{addr: req_addr, we: req_we, wstrb: req_wstrb, wdata: req_wdata};
      cnt_d   = CNT_LOAD;
      state_d = WAIT;
    end
  end

  // active_q keeps req_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
      active_q <= 1'b1;
    end
  end

  mem_responder_array #(.AW(ADDR_WIDTH)) u_array (
    .clk_i   (clk),
    .en_i    (commit && !cur_err),
    .we_i    (req_q.we),
    .wstrb_i (req_q.wstrb),
    .addr_i  (req_q.addr[ADDR_WIDTH+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );

  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rd_sel_q ? ram_rdata : 32'd0;
  assign resp_err    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table, backpressure, reset-in-WAIT and
// back-to-back throughput sequences.
`timescale 1ns/1ps
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int AW  = 12;
  localparam int LAT = 2;
`ifdef MEM_RESPONDER_BACK_TO_BACK_EN
  localparam int EXP_B2B = 24;
`else
  localparam int EXP_B2B = 32;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_wstrb = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_wstrb   (req_wstrb),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    int g;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = wdata;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          first, last, acc, nresp, g;

    vecs.push_back('{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0008, 4'hF, 32'hAABB_CCDD, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_0008, 4'h5, 32'h1122_3344, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0008, 4'h0, 32'h0,         32'hAA22_CC44, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0102, 4'h0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0008, 4'h0, 32'hFFFF_FFFF, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0008, 4'h0, 32'h0,         32'hAA22_CC44, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_3FFC, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_3FFC, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_0000, 4'h0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h0000_0020, 4'hF, 32'h55AA_55AA, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_0021, 4'hF, 32'h0000_0000, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h55AA_55AA, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].strb, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
    end

    // Backpressure: hold RESP for 10 cycles with a competing request pending
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_wstrb = 4'h0;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 req_addr = 32'h8;
    g = 0;
    while (!resp_valid && g < 20) begin @(posedge clk); #1; g++; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_state", 32'(dbg_state), 32'(IDLE));

    // Reset during WAIT discards the pending write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wstrb = 4'hF; req_wdata = 32'hFFFF_FFFF;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("wr_in_wait", 32'(dbg_state), 32'(WAIT));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_rdata", resp_rdata, 32'd0);
    check("midrst_err", 32'(resp_err), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    issue(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    check("midrst_readback", rd, 32'h55AA_55AA);
    check("midrst_readback_err", 32'(er), 32'd0);

    // Back-to-back reads: cycles between the 1st and 9th accept equal 8 request periods
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_wstrb = 4'h0;
    first = -1; last = -1; acc = 0; nresp = 0;
    for (int c = 0; c < 200 && acc < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid) begin
        nresp++;
        if (exp_q.size() > 0) check("b2b_rdata", resp_rdata, exp_q.pop_front());
        else check("b2b_unexpected_resp", 32'(resp_valid), 32'd0);
      end
      if (req_ready) begin
        if (acc == 0) first = c;
        acc++;
        if (acc == 9) last = c;
        exp_q.push_back(32'hDEAD_BEEF);
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    g = 0;
    while (!resp_valid && g < 20) begin @(negedge clk); g++; end
    @(negedge clk);
    check("b2b_last_rdata", resp_rdata, exp_q.size() > 0 ? exp_q.pop_front() : 32'hXXXX_XXXX);
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd9);
    check("b2b_responses", 32'(nresp), 32'd8);
    check("b2b_cycles", 32'(last - first), 32'(EXP_B2B));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
